ram_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_sel.sv | 24 ++
 rtl/ram_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Port ids double as the 1-bit round-robin "last" encoding.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;

endpackage

// File: rtl/ram_arb_sel.sv
// Combinational winner pick between CPU and debug requests; zero latency, no backpressure.
// RAM_ARB_RR_EN selects round-robin on ties, otherwise CPU has fixed priority.
module ram_arb_sel
  import ram_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
`ifdef RAM_ARB_RR_EN
  input  logic last,
`endif
  output logic any_req,
  output logic win
);

  assign any_req = cpu_req | dbg_req;

`ifdef RAM_ARB_RR_EN
  // On a tie the port that was not served last time goes first.
  assign win = (cpu_req && dbg_req) ? ~last : (dbg_req ? PORT_DBG : PORT_CPU);
`else
  assign win = (dbg_req && !cpu_req) ? PORT_DBG : PORT_CPU;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between CPU and debug ports (RAM_ARB_RR_EN: round-robin ties).
// Grant one cycle after req is sampled, rvalid one cycle later; losers hold req until granted.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  logic              lat_port;
  logic              lat_we;
  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ARB_RR_EN
  logic last;

  ram_arb_sel u_sel (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .last    (last),
    .any_req (any_req),
    .win     (win)
  );
`else
  ram_arb_sel u_sel (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .any_req (any_req),
    .win     (win)
  );
`endif

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (win == PORT_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // The ram_* registers hold the latched address/data; they are only non-zero in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_port   <= PORT_CPU;
      lat_we     <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last       <= PORT_DBG;
`endif
    end else begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state     <= GRANT;
            lat_port  <= win;
            lat_we    <= sel_we;
            ram_en    <= 1'b1;
            ram_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            cpu_gnt   <= (win == PORT_CPU);
            dbg_gnt   <= (win == PORT_DBG);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
`ifdef RAM_ARB_RR_EN
          last       <= lat_port;
`endif
          state      <= lat_we ? IDLE : RESP;
          cpu_rvalid <= !lat_we && (lat_port == PORT_CPU);
          dbg_rvalid <= !lat_we && (lat_port == PORT_DBG);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous 32x8 RAM.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [7:0] pre_dat = '0;
  logic [7:0] mem [32];

  logic [34:0] outs;
  logic [7:0]  stream_exp [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  assign outs = {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata,
                 ram_en, ram_we, ram_addr, ram_wdata};

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 35'd0) begin errors++; $display("FAIL reset_outs got %h want 0", outs); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 35'd0) begin errors++; $display("FAIL post_reset_outs got %h want 0", outs); end
  endtask

  task automatic test_cpu_read;
    preload(5'd3, 8'hA5);
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_en, ram_we, ram_addr} !== {4'b1010, 5'd3}) begin
      errors++; $display("FAIL cpu_read_grant got %b want 1010_00011", {cpu_gnt, dbg_gnt, ram_en, ram_we, ram_addr});
    end
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata, dbg_rvalid, ram_en} !== {1'b1, 8'hA5, 2'b00}) begin
      errors++; $display("FAIL cpu_read_data got rvalid=%b rdata=%h dbg_rvalid=%b ram_en=%b want 1 a5 0 0",
                         cpu_rvalid, cpu_rdata, dbg_rvalid, ram_en);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== 9'd0) begin
      errors++; $display("FAIL cpu_read_after got rvalid=%b rdata=%h want 0 00", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_dbg_write_cpu_read;
    @(negedge clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd7; dbg_wdata = 8'h3C;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, cpu_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {4'b1011, 5'd7, 8'h3C}) begin
      errors++; $display("FAIL dbg_write_grant got %b want 1011_00111_00111100",
                         {dbg_gnt, cpu_gnt, ram_en, ram_we, ram_addr, ram_wdata});
    end
    dbg_req = 0; dbg_we = 0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, dbg_rvalid, dbg_gnt} !== 4'b0000) begin
      errors++; $display("FAIL dbg_write_one_cycle got %b want 0000", {ram_en, ram_we, dbg_rvalid, dbg_gnt});
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ram_addr} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL readback_grant got gnt=%b addr=%0d want 1 7", cpu_gnt, ram_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL readback_data got rvalid=%b rdata=%h want 1 3c", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_simultaneous;
    logic exp_port;
    preload(5'd1, 8'h11);
    preload(5'd2, 8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd2;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
      exp_port = (k % 2 == 1) ? PORT_DBG : PORT_CPU;
`else
      exp_port = PORT_CPU;
`endif
      @(negedge clk);
      checks++;
      if ({cpu_gnt, dbg_gnt} !== {exp_port == PORT_CPU, exp_port == PORT_DBG}) begin
        errors++; $display("FAIL tie_grant%0d got cpu=%b dbg=%b want port %0d", k, cpu_gnt, dbg_gnt, exp_port);
      end
      if (k == 3) begin cpu_req = 0; dbg_req = 0; end
      @(negedge clk);
      checks++;
      if (exp_port == PORT_CPU) begin
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid} !== {1'b1, 8'h11, 1'b0}) begin
          errors++; $display("FAIL tie_data%0d got cpu_rvalid=%b cpu_rdata=%h dbg_rvalid=%b want 1 11 0",
                             k, cpu_rvalid, cpu_rdata, dbg_rvalid);
        end
      end else begin
        if ({dbg_rvalid, dbg_rdata, cpu_rvalid} !== {1'b1, 8'h22, 1'b0}) begin
          errors++; $display("FAIL tie_data%0d got dbg_rvalid=%b dbg_rdata=%h cpu_rvalid=%b want 1 22 0",
                             k, dbg_rvalid, dbg_rdata, cpu_rvalid);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_en} !== 3'b000) begin
      errors++; $display("FAIL tie_release got %b want 000", {cpu_gnt, dbg_gnt, ram_en});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL mid_reset_grant got %b want 1", cpu_gnt); end
    rst = 1'b1; cpu_req = 0;
    @(negedge clk);
    checks++;
    if (outs !== 35'd0) begin errors++; $display("FAIL mid_reset_outs got %h want 0", outs); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL mid_reset_state got %0d want %0d", dut.state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 35'd0) begin errors++; $display("FAIL mid_reset_no_rvalid got %h want 0", outs); end
  endtask

  task automatic test_read_stream;
    stream_exp[0] = 8'h10; stream_exp[1] = 8'h21; stream_exp[2] = 8'h32;
    stream_exp[3] = 8'h43; stream_exp[4] = 8'h54;
    for (int i = 0; i < 5; i++) preload(5'(i), stream_exp[i]);
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ram_en, ram_addr} !== {2'b11, 5'(i)}) begin
        errors++; $display("FAIL stream_grant%0d got gnt=%b en=%b addr=%0d want 1 1 %0d", i, cpu_gnt, ram_en, ram_addr, i);
      end
      if (i == 4) cpu_req = 0;
      else        cpu_addr = 5'(i + 1);
      @(negedge clk);
      checks++;
      if ({cpu_gnt, cpu_rvalid, cpu_rdata} !== {2'b01, stream_exp[i]}) begin
        errors++; $display("FAIL stream_data%0d got gnt=%b rvalid=%b rdata=%h want 0 1 %h",
                           i, cpu_gnt, cpu_rvalid, cpu_rdata, stream_exp[i]);
      end
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, cpu_gnt, dbg_gnt} !== 3'b000 || dut.state !== IDLE) begin
        errors++; $display("FAIL idle%0d got en=%b gnts=%b%b state=%0d want 0 00 %0d",
                           i, ram_en, cpu_gnt, dbg_gnt, dut.state, IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write_cpu_read();
    test_simultaneous();
    test_reset_mid();
    test_read_stream();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
